ca_frame_sequencer: RTL and testbench

// - Sequences the 1-D cellular-automaton scan datapath behind the VGA timing generator, once per frame.
// - Decides the rule byte, the seed row, and the cell-shift enable for each frame.
// - Accepts rule updates from a requester through a valid/ready handshake and commits them only at frame boundaries.
// - Auto-advances the rule after a programmable number of frames.

---
 rtl/ca_pkg.sv | 16 +
 rtl/ca_frame_tick.sv | 27 ++
 rtl/ca_frame_sequencer.sv | 135 +++++++++++++
 tb/tb_ca_frame_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton frame sequencer.
// Holds the FSM state enum, the reset rule and the LFSR seed constants.
package ca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } ca_state_e;

  localparam logic [7:0]  RULE_RESET = 8'd90;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_INIT  = 16'hACE1;

endpackage

// File: rtl/ca_frame_tick.sv
// Frame tick: registered 1-cycle pulse after the last pixel of a frame.
// Ports: clk, rst_n, hpos, vpos in; tick out.
module ca_frame_tick #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic       tick
);

  logic w_last;
  logic r_tick;

  assign w_last = (hpos == 10'(H_TOTAL - 1)) &&
                  (vpos == 10'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick <= 1'b0;
    else        r_tick <= w_last;
  end

  assign tick = r_tick;

endmodule

// File: rtl/ca_frame_sequencer.sv
// Per-frame sequencer for the 1-D CA scan datapath: rule, seed, shift.
// Ports: clk, rst_n, hpos, vpos, display_on, cfg_* handshake, pause in;
// rule, seed_row, seed_bit, shift_en, frame_cnt, cfg_ready out.
// Macro CA_LFSR_SEED_EN swaps the single-cell seed for a 16-bit LFSR.
module ca_frame_sequencer
  import ca_pkg::*;
#(
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525,
  parameter int SEED_CELL = 160,
  parameter int DWELL_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  input  logic               display_on,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [7:0]         cfg_rule,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               pause,
  output logic [7:0]         rule,
  output logic               seed_row,
  output logic               seed_bit,
  output logic               shift_en,
  output logic [15:0]        frame_cnt
);

  ca_state_e          r_state;
  logic [7:0]         r_rule;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_pend;
  logic [7:0]         r_pend_rule;
  logic [DWELL_W-1:0] r_pend_dwell;
  logic               r_cfg_ready;
  logic [15:0]        r_frame_cnt;
  logic               w_tick;
  logic               w_xfer;
  logic               w_frozen;
  logic               w_expire;

  ca_frame_tick #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .hpos  (hpos),
    .vpos  (vpos),
    .tick  (w_tick)
  );

  assign w_xfer   = cfg_valid & r_cfg_ready;
  assign w_frozen = (r_state == HOLD);
  assign w_expire = (r_dwell != '0) &&
                    (r_dwell_cnt == r_dwell - DWELL_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rule       <= RULE_RESET;
      r_dwell      <= '0;
      r_dwell_cnt  <= '0;
      r_pend       <= 1'b0;
      r_pend_rule  <= '0;
      r_pend_dwell <= '0;
      r_cfg_ready  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      // ready lags pend by one cycle so it reopens after the commit
      if (w_xfer) r_cfg_ready <= 1'b0;
      else        r_cfg_ready <= ~r_pend;

      if (w_tick && r_pend) begin
        r_pend <= 1'b0;
      end else if (w_xfer) begin
        r_pend       <= 1'b1;
        r_pend_rule  <= cfg_rule;
        r_pend_dwell <= cfg_dwell;
      end

      if (w_tick) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_pend) begin
          r_rule      <= r_pend_rule;
          r_dwell     <= r_pend_dwell;
          r_dwell_cnt <= '0;
          r_state     <= SEED;
        end else if (pause) begin
          r_state <= HOLD;
        end else begin
          unique case (r_state)
            IDLE: r_state <= SEED;
            SEED: r_state <= RUN;
            HOLD: r_state <= RUN;
            RUN: begin
              if (w_expire) begin
                r_rule      <= r_rule + 8'd1;
                r_dwell_cnt <= '0;
                r_state     <= SEED;
              end else if (r_dwell != '0) begin
                r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
              end
            end
            default: r_state <= IDLE;
          endcase
        end
      end
    end
  end

  assign seed_row = display_on && (vpos == 10'd0) && !w_frozen;
  assign shift_en = display_on && hpos[0] && !w_frozen;

`ifdef CA_LFSR_SEED_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= LFSR_INIT;
    else if (shift_en && seed_row)
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0);
  end

  assign seed_bit = r_lfsr[0];
`else
  assign seed_bit = (hpos[9:1] == 9'(SEED_CELL));
`endif

  assign rule      = r_rule;
  assign cfg_ready = r_cfg_ready;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_ca_frame_sequencer.sv
// Directed bench for ca_frame_sequencer.
// Drives hpos/vpos directly so each frame tick costs two clocks.
module tb_ca_frame_sequencer;
  import ca_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos, vpos;
  logic        display_on, cfg_valid, cfg_ready;
  logic [7:0]  cfg_rule, rule;
  logic [7:0]  cfg_dwell;
  logic        pause, seed_row, seed_bit, shift_en;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  ca_frame_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_rule   (cfg_rule),
    .cfg_dwell  (cfg_dwell),
    .pause      (pause),
    .rule       (rule),
    .seed_row   (seed_row),
    .seed_bit   (seed_bit),
    .shift_en   (shift_en),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one frame boundary: last pixel, then the tick cycle
  task automatic tick();
    hpos = 10'd799;
    vpos = 10'd524;
    step();
    hpos = 10'd0;
    vpos = 10'd0;
    step();
  endtask

  task automatic offer(input logic [7:0] r, input logic [7:0] d);
    cfg_rule  = r;
    cfg_dwell = d;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; hpos = '0; vpos = '0;
    display_on = 1'b0; cfg_valid = 1'b0;
    cfg_rule = '0; cfg_dwell = '0; pause = 1'b0;
    repeat (3) step();
    chk("rst_rule", 32'(rule), 32'd90);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
    chk("rst_srow", 32'(seed_row), 32'd0);
    chk("rst_shift", 32'(shift_en), 32'd0);
    chk("rst_sbit", 32'(seed_bit), 32'd0);

    rst_n = 1'b1;
    step();
    chk("ready_up", 32'(cfg_ready), 32'd1);
    tick();
    chk("t1_state", 32'(dut.r_state), 32'(SEED));
    chk("t1_rule", 32'(rule), 32'd90);
    chk("t1_fcnt", 32'(frame_cnt), 32'd1);

    display_on = 1'b1; vpos = 10'd0; hpos = 10'd320; #1;
    chk("srow_v0", 32'(seed_row), 32'd1);
    chk("sbit_320", 32'(seed_bit), 32'd1);
    chk("shift_even", 32'(shift_en), 32'd0);
    hpos = 10'd321; #1;
    chk("sbit_321", 32'(seed_bit), 32'd1);
    chk("shift_odd", 32'(shift_en), 32'd1);
    hpos = 10'd322; #1;
    chk("sbit_322", 32'(seed_bit), 32'd0);
    hpos = 10'd319; #1;
    chk("sbit_319", 32'(seed_bit), 32'd0);
    vpos = 10'd1; hpos = 10'd320; #1;
    chk("srow_v1", 32'(seed_row), 32'd0);
    vpos = 10'd0; display_on = 1'b0; #1;
    chk("srow_blank", 32'(seed_row), 32'd0);
    display_on = 1'b1;

    hpos = 10'd400; vpos = 10'd200;
    offer(8'd30, 8'd0);
    chk("xfer_ready", 32'(cfg_ready), 32'd0);
    chk("xfer_rule", 32'(rule), 32'd90);
    tick();
    chk("c30_rule", 32'(rule), 32'd30);
    chk("c30_ready", 32'(cfg_ready), 32'd0);
    chk("c30_state", 32'(dut.r_state), 32'(SEED));
    step();
    chk("c30_ready1", 32'(cfg_ready), 32'd1);
    tick();
    chk("t3_state", 32'(dut.r_state), 32'(RUN));

    offer(8'd254, 8'd3);
    tick();
    chk("c254_rule", 32'(rule), 32'd254);
    tick();
    tick();
    tick();
    chk("dw_hold", 32'(rule), 32'd254);
    tick();
    chk("dw_255", 32'(rule), 32'd255);
    chk("dw_seed1", 32'(dut.r_state), 32'(SEED));
    tick();
    tick();
    tick();
    chk("dw_hold2", 32'(rule), 32'd255);
    tick();
    chk("dw_wrap", 32'(rule), 32'd0);
    chk("dw_seed2", 32'(dut.r_state), 32'(SEED));
    chk("f12_fcnt", 32'(frame_cnt), 32'd12);

    tick();
    pause = 1'b1;
    tick();
    chk("hold_state", 32'(dut.r_state), 32'(HOLD));
    chk("hold_fcnt", 32'(frame_cnt), 32'd14);
    for (int i = 0; i < 6; i++) begin
      hpos = 10'(2 * i * 61 + 1);
      vpos = 10'(i * 80);
      #1;
      chk("hold_shift", 32'(shift_en), 32'd0);
    end
    vpos = 10'd0; hpos = 10'd321; #1;
    chk("hold_srow", 32'(seed_row), 32'd0);
    pause = 1'b0;
    tick();
    chk("unhold_st", 32'(dut.r_state), 32'(RUN));
    hpos = 10'd321; #1;
    chk("unhold_sh", 32'(shift_en), 32'd1);
    chk("unhold_rule", 32'(rule), 32'd0);

    tick();
    tick();
    chk("pri_pre", 32'(dut.r_dwell_cnt), 32'd2);
    pause = 1'b1;
    offer(8'd77, 8'd5);
    tick();
    pause = 1'b0;
    chk("pri_rule", 32'(rule), 32'd77);
    chk("pri_state", 32'(dut.r_state), 32'(SEED));
    chk("pri_dcnt", 32'(dut.r_dwell_cnt), 32'd0);
    chk("pri_fcnt", 32'(frame_cnt), 32'd18);

    step();
    hpos = 10'd400; vpos = 10'd200;
    offer(8'd11, 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_rule", 32'(rule), 32'd90);
    chk("mrst_ready", 32'(cfg_ready), 32'd0);
    chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
    #1 rst_n = 1'b1;
    step();
    tick();
    chk("mrst_drop", 32'(rule), 32'd90);
    chk("mrst_seed", 32'(dut.r_state), 32'(SEED));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
